// File: rtl/vc_fifo_bank.sv
// Bank of NCH independent per-virtual-channel FIFOs behind one shared write port and one shared read port.
// Each channel has its own occupancy count, threshold flags and sticky error bit.
module vc_fifo_bank #(
    parameter int unsigned BW  = 6,
    parameter int unsigned LEN = 4,
    parameter int unsigned NCH = 4,
    parameter int unsigned CHW = 2
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic                     wr,
    input  logic [CHW-1:0]           wr_ch,
    input  logic [BW-1:0]            data_in,
    input  logic                     rd,
    input  logic [CHW-1:0]           rd_ch,
    input  logic [NCH*LEN-1:0]       umbral_bajo,
    input  logic [NCH*LEN-1:0]       umbral_alto,
    input  logic [NCH-1:0]           err_clr,
    output logic [BW-1:0]            data_out,
    output logic                     data_valid,
    output logic [NCH-1:0]           error_output,
    output logic [NCH-1:0]           full,
    output logic [NCH-1:0]           empty,
    output logic [NCH-1:0]           almost_full,
    output logic [NCH-1:0]           almost_empty,
    output logic [NCH*(LEN+1)-1:0]   count
);

    localparam int unsigned DEPTH = 2**LEN;
    localparam int unsigned CW    = LEN + 1;

    logic [BW-1:0]  r_mem  [NCH][DEPTH];
    logic [LEN-1:0] r_wptr [NCH];
    logic [LEN-1:0] r_rptr [NCH];
    logic [CW-1:0]  r_cnt  [NCH];
    logic [NCH-1:0] r_err;
    logic [BW-1:0]  r_dout;
    logic           r_dv;

    logic [NCH-1:0] w_wr_sel;
    logic [NCH-1:0] w_rd_sel;
    logic [NCH-1:0] w_wr_ok;
    logic [NCH-1:0] w_rd_ok;
    logic [NCH-1:0] w_err_set;
    logic [BW-1:0]  w_rd_word;

    // Per-channel request decode; a full channel still accepts a write when it is read in the same cycle.
    always_comb begin
        w_wr_sel  = '0;
        w_rd_sel  = '0;
        w_wr_ok   = '0;
        w_rd_ok   = '0;
        w_err_set = '0;
        w_rd_word = '0;
        for (int c = 0; c < NCH; c++) begin
            w_wr_sel[c]  = wr && (wr_ch == CHW'(c));
            w_rd_sel[c]  = rd && (rd_ch == CHW'(c));
            w_rd_ok[c]   = w_rd_sel[c] && (r_cnt[c] != '0);
            w_wr_ok[c]   = w_wr_sel[c] && ((r_cnt[c] != CW'(DEPTH)) || w_rd_ok[c]);
            w_err_set[c] = (w_wr_sel[c] && !w_wr_ok[c]) || (w_rd_sel[c] && !w_rd_ok[c]);
            if (w_rd_ok[c]) begin
                w_rd_word = r_mem[c][r_rptr[c]];
            end
        end
    end

    // Storage array is not reset; pointer reset alone discards its contents.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (w_wr_ok[c]) begin
                r_mem[c][r_wptr[c]] <= data_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int c = 0; c < NCH; c++) begin
                r_wptr[c] <= '0;
                r_rptr[c] <= '0;
                r_cnt[c]  <= '0;
            end
            r_err  <= '0;
            r_dout <= '0;
            r_dv   <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (w_wr_ok[c]) begin
                    r_wptr[c] <= r_wptr[c] + LEN'(1);
                end
                if (w_rd_ok[c]) begin
                    r_rptr[c] <= r_rptr[c] + LEN'(1);
                end
                case ({w_wr_ok[c], w_rd_ok[c]})
                    2'b10:   r_cnt[c] <= r_cnt[c] + CW'(1);
                    2'b01:   r_cnt[c] <= r_cnt[c] - CW'(1);
                    default: r_cnt[c] <= r_cnt[c];
                endcase
                // A set event in the same cycle as a clear keeps the bit set.
                if (w_err_set[c]) begin
                    r_err[c] <= 1'b1;
                end else if (err_clr[c]) begin
                    r_err[c] <= 1'b0;
                end
            end
            r_dv <= |w_rd_ok;
            if (|w_rd_ok) begin
                r_dout <= w_rd_word;
            end
        end
    end

    // Status flags are decoded straight from the registered counts.
    always_comb begin
        full         = '0;
        empty        = '0;
        almost_full  = '0;
        almost_empty = '0;
        count        = '0;
        for (int c = 0; c < NCH; c++) begin
            full[c]          = (r_cnt[c] == CW'(DEPTH));
            empty[c]         = (r_cnt[c] == '0);
            almost_full[c]   = (r_cnt[c] >= {1'b0, umbral_alto[c*LEN +: LEN]});
            almost_empty[c]  = (r_cnt[c] <= {1'b0, umbral_bajo[c*LEN +: LEN]});
            count[c*CW +: CW] = r_cnt[c];
        end
    end

    assign data_out     = r_dout;
    assign data_valid   = r_dv;
    assign error_output = r_err;

endmodule
